// File: rtl/sprite_row_renderer.sv
// sprite_row_renderer: draws one horizontal row of N_SPR identical, individually
// maskable sprites scaled by SCALE, from a live two-frame bitmap. spr_draw names
// the 1-based sprite whose opaque pixel covers the pixel_x seen one cycle earlier.
// Column and row positions come from counters that start when pixel_x hits a
// sprite base, so no divider is needed. This relies on pixel_x stepping by one
// per clock from the start of every scanline.
module sprite_row_renderer #(
  parameter int N_SPR = 11,
  parameter int SPR_W = 13,
  parameter int SPR_H = 8,
  parameter int SCALE = 2,
  parameter int PITCH = 32,
  parameter int X_W   = 10,
  parameter int IDX_W = $clog2(N_SPR + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       line_end,
  input  logic                       frame,
  input  logic [X_W-1:0]             spr_x,
  input  logic [X_W-1:0]             pixel_x,
  input  logic [N_SPR-1:0]           mask,
  input  logic [2*SPR_H*SPR_W-1:0]   bitmap,
  output logic [IDX_W-1:0]           spr_draw,
  output logic                       busy,
  output logic                       done
);

  // Bases are held wide enough that sprites past the right screen edge never
  // wrap back into the visible range.
  localparam int BASE_W     = X_W + $clog2(N_SPR) + 1;
  localparam int COL_W      = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int ROW_W      = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam int SUB_W      = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int FRAME_BITS = SPR_H * SPR_W;
  localparam int BI_W       = $clog2(2 * FRAME_BITS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_LINE = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t              state_r;
  logic                frame_r;
  logic [N_SPR-1:0]    mask_r;
  logic [X_W-1:0]      spr_x_r;
  // Scanline index within the row is row_r*SCALE + lsub_r.
  logic [ROW_W-1:0]    row_r;
  logic [SUB_W-1:0]    lsub_r;
  // Next sprite to look for on this scanline, and its screen base.
  logic [IDX_W-1:0]    nxt_k_r;
  logic [BASE_W-1:0]   base_r;
  // Sprite currently being traced, with its column and horizontal sub-pixel.
  logic                act_r;
  logic [IDX_W-1:0]    act_k_r;
  logic [COL_W-1:0]    col_r;
  logic [SUB_W-1:0]    sub_r;
  logic [IDX_W-1:0]    spr_draw_r;
  logic                busy_r;
  logic                done_r;

  logic [BASE_W-1:0]   px_ext_s;
  logic [BASE_W-1:0]   sx_ext_s;
  logic                hit_s;
  logic                cur_vld_s;
  logic [IDX_W-1:0]    cur_k_s;
  logic [COL_W-1:0]    cur_col_s;
  logic [SUB_W-1:0]    cur_sub_s;
  logic [BI_W-1:0]     bit_idx_s;
  logic                opaque_s;
  logic [IDX_W-1:0]    draw_s;
  logic                nxt_act_s;
  logic [COL_W-1:0]    nxt_col_s;
  logic [SUB_W-1:0]    nxt_sub_s;

  assign px_ext_s = {{(BASE_W - X_W){1'b0}}, pixel_x};
  assign sx_ext_s = {{(BASE_W - X_W){1'b0}}, spr_x_r};
  assign spr_draw = spr_draw_r;
  assign busy     = busy_r;
  assign done     = done_r;

  // Decide which sprite and column cover the current pixel, and the counter
  // state for the next pixel.
  always_comb begin
    hit_s     = 1'b0;
    cur_vld_s = 1'b0;
    cur_k_s   = '0;
    cur_col_s = '0;
    cur_sub_s = '0;
    nxt_act_s = 1'b0;
    nxt_col_s = '0;
    nxt_sub_s = '0;
    if ((state_r == ST_LINE) && (nxt_k_r != IDX_W'(N_SPR)) && (px_ext_s == base_r)) begin
      hit_s     = 1'b1;
      cur_vld_s = 1'b1;
      cur_k_s   = nxt_k_r;
    end else if ((state_r == ST_LINE) && act_r) begin
      cur_vld_s = 1'b1;
      cur_k_s   = act_k_r;
      cur_col_s = col_r;
      cur_sub_s = sub_r;
    end else begin
      cur_vld_s = 1'b0;
    end

    bit_idx_s = BI_W'(int'(frame_r) * FRAME_BITS + int'(row_r) * SPR_W
                      + (SPR_W - 1 - int'(cur_col_s)));
    opaque_s  = cur_vld_s && mask_r[cur_k_s] && bitmap[bit_idx_s];
    draw_s    = opaque_s ? (cur_k_s + IDX_W'(1)) : '0;

    // Tracing stops at the sprite's last column or at the right screen edge.
    if (!cur_vld_s) begin
      nxt_act_s = 1'b0;
    end else if (pixel_x == {X_W{1'b1}}) begin
      nxt_act_s = 1'b0;
    end else if (cur_sub_s == SUB_W'(SCALE - 1)) begin
      if (cur_col_s == COL_W'(SPR_W - 1)) begin
        nxt_act_s = 1'b0;
      end else begin
        nxt_act_s = 1'b1;
        nxt_col_s = cur_col_s + COL_W'(1);
        nxt_sub_s = '0;
      end
    end else begin
      nxt_act_s = 1'b1;
      nxt_col_s = cur_col_s;
      nxt_sub_s = cur_sub_s + SUB_W'(1);
    end
  end

  // Row sequencer: latches the row setup, counts scanlines and pixel counters,
  // and registers all outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      frame_r    <= 1'b0;
      mask_r     <= '0;
      spr_x_r    <= '0;
      row_r      <= '0;
      lsub_r     <= '0;
      nxt_k_r    <= '0;
      base_r     <= '0;
      act_r      <= 1'b0;
      act_k_r    <= '0;
      col_r      <= '0;
      sub_r      <= '0;
      spr_draw_r <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          spr_draw_r <= '0;
          done_r     <= 1'b0;
          row_r      <= '0;
          lsub_r     <= '0;
          act_r      <= 1'b0;
          if (start) begin
            frame_r <= frame;
            mask_r  <= mask;
            spr_x_r <= spr_x;
            busy_r  <= 1'b1;
            state_r <= ST_ARM;
          end else begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_ARM: begin
          spr_draw_r <= '0;
          done_r     <= 1'b0;
          busy_r     <= 1'b1;
          row_r      <= '0;
          lsub_r     <= '0;
          nxt_k_r    <= '0;
          base_r     <= sx_ext_s;
          act_r      <= 1'b0;
          col_r      <= '0;
          sub_r      <= '0;
          if (line_end) begin
            state_r <= ST_LINE;
          end else begin
            state_r <= ST_ARM;
          end
        end
        ST_LINE: begin
          spr_draw_r <= draw_s;
          done_r     <= 1'b0;
          if (line_end) begin
            // A new scanline restarts the search from sprite 1; anything
            // still pending on this line is dropped.
            nxt_k_r <= '0;
            base_r  <= sx_ext_s;
            act_r   <= 1'b0;
            col_r   <= '0;
            sub_r   <= '0;
            if ((row_r == ROW_W'(SPR_H - 1)) && (lsub_r == SUB_W'(SCALE - 1))) begin
              row_r   <= '0;
              lsub_r  <= '0;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              state_r <= ST_DONE;
            end else begin
              busy_r  <= 1'b1;
              state_r <= ST_LINE;
              if (lsub_r == SUB_W'(SCALE - 1)) begin
                lsub_r <= '0;
                row_r  <= row_r + ROW_W'(1);
              end else begin
                lsub_r <= lsub_r + SUB_W'(1);
              end
            end
          end else begin
            busy_r  <= 1'b1;
            state_r <= ST_LINE;
            if (hit_s) begin
              nxt_k_r <= nxt_k_r + IDX_W'(1);
              base_r  <= base_r + BASE_W'(PITCH);
            end else begin
              nxt_k_r <= nxt_k_r;
              base_r  <= base_r;
            end
            act_r   <= nxt_act_s;
            act_k_r <= cur_k_s;
            col_r   <= nxt_col_s;
            sub_r   <= nxt_sub_s;
          end
        end
        ST_DONE: begin
          spr_draw_r <= '0;
          done_r     <= 1'b0;
          busy_r     <= 1'b0;
          state_r    <= ST_IDLE;
        end
        default: begin
          spr_draw_r <= '0;
          done_r     <= 1'b0;
          busy_r     <= 1'b0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_row_renderer.sv
// Bench for sprite_row_renderer: drives scanline sweeps and compares every cycle
// against a row model that applies the sprite coverage rule with plain division.
module tb_sprite_row_renderer;

  localparam int N_SPR = 11;
  localparam int SPR_W = 13;
  localparam int SPR_H = 8;
  localparam int SCALE = 2;
  localparam int PITCH = 32;
  localparam int X_W   = 10;
  localparam int IDX_W = $clog2(N_SPR + 1);
  localparam int FB    = SPR_H * SPR_W;
  localparam int LINES = SPR_H * SCALE;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 line_end;
  logic                 frame;
  logic [X_W-1:0]       spr_x;
  logic [X_W-1:0]       pixel_x;
  logic [N_SPR-1:0]     mask;
  logic [2*FB-1:0]      bitmap;
  logic [IDX_W-1:0]     spr_draw;
  logic                 busy;
  logic                 done;

  int errors = 0;
  int checks = 0;

  // Model state
  bit               m_busy;
  bit               m_done;
  int               m_line;
  int               m_frame;
  int               m_spx;
  logic [N_SPR-1:0] m_mask;
  int               exp_draw;
  int               exp_busy;
  int               exp_done;

  int pin_px[$];
  int pin_val[$];
  int nz_cnt;
  int s1_cnt;
  int arm_nz;

  sprite_row_renderer #(
    .N_SPR(N_SPR), .SPR_W(SPR_W), .SPR_H(SPR_H), .SCALE(SCALE),
    .PITCH(PITCH), .X_W(X_W), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .line_end(line_end), .frame(frame),
    .spr_x(spr_x), .pixel_x(pixel_x), .mask(mask), .bitmap(bitmap),
    .spr_draw(spr_draw), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Which sprite's opaque pixel covers px on bitmap row r (0 = none).
  function automatic int rule(int px, int r);
    int b;
    int c;
    for (int k = 0; k < N_SPR; k++) begin
      b = m_spx + k * PITCH;
      if (px >= b && px < b + SPR_W * SCALE) begin
        c = (px - b) / SCALE;
        if (m_mask[k] && bitmap[m_frame * FB + r * SPR_W + (SPR_W - 1 - c)]) return k + 1;
      end
    end
    return 0;
  endfunction

  // Advance the row model by one clock using the inputs about to be sampled.
  task automatic model_step();
    if (!rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_line = -1; exp_draw = 0;
      m_frame = 0; m_spx = 0; m_mask = '0;
    end else begin
      exp_draw = (m_busy && m_line >= 0) ? rule(int'(pixel_x), m_line / SCALE) : 0;
      if (m_done) begin
        m_done = 1'b0;
      end else if (!m_busy) begin
        if (start) begin
          m_busy = 1'b1; m_line = -1;
          m_frame = int'(frame); m_spx = int'(spr_x); m_mask = mask;
        end
      end else if (line_end) begin
        if (m_line < 0) m_line = 0;
        else if (m_line == LINES - 1) begin
          m_busy = 1'b0; m_done = 1'b1; m_line = -1;
        end else m_line++;
      end
    end
    exp_busy = int'(m_busy);
    exp_done = int'(m_done);
  endtask

  task automatic chk(string name, logic [31:0] act, int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0d expected %0d (t=%0t px=%0d)", name, act, exp, $time, pixel_x);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("spr_draw", 32'(spr_draw), exp_draw);
    chk("busy", 32'(busy), exp_busy);
    chk("done", 32'(done), exp_done);
    start = 1'b0;
    line_end = 1'b0;
  endtask

  task automatic pin(int px, int v);
    pin_px.push_back(px);
    pin_val.push_back(v);
  endtask

  // One scanline sweep 0..width-1 with line_end on the last pixel.
  task automatic sweep(int width, bit pins_on, int hk_px, int hk_kind);
    nz_cnt = 0;
    for (int p = 0; p < width; p++) begin
      pixel_x = X_W'(p);
      line_end = (p == width - 1);
      if (p == hk_px) begin
        case (hk_kind)
          1: begin mask = '1; frame = ~frame; spr_x = X_W'($urandom_range(0, 1023)); end
          2: rst = 1'b0;
          3: start = 1'b1;
          default: ;
        endcase
      end
      tick();
      if (p == hk_px && hk_kind == 2) begin
        chk("rst_draw", 32'(spr_draw), 0);
        chk("rst_busy", 32'(busy), 0);
      end
      rst = 1'b1;
      if (spr_draw != '0) nz_cnt++;
      if (spr_draw == IDX_W'(1)) s1_cnt++;
      if (pins_on)
        foreach (pin_px[i]) if (pin_px[i] == p) chk("pin_draw", 32'(spr_draw), pin_val[i]);
    end
  endtask

  // A full row: optional start, an arming scanline, then LINES scanlines.
  task automatic do_row(bit issue_start, int arm_w, int w0, int wrest,
                        int hk_line, int hk_px, int hk_kind);
    int w;
    s1_cnt = 0;
    if (issue_start) begin start = 1'b1; tick(); end
    if (arm_w > 0) begin
      sweep(arm_w, 1'b0, -1, 0);
      arm_nz = nz_cnt;
    end
    for (int l = 0; l < LINES; l++) begin
      if (l == 0 && w0 > 0) w = w0;
      else if (wrest > 0) w = wrest;
      else w = int'($urandom_range(20, 1024));
      sweep(w, l == 0, (l == hk_line) ? hk_px : -1, hk_kind);
    end
    pin_px.delete();
    pin_val.delete();
  endtask

  task automatic rand_bitmap();
    for (int i = 0; i < 2 * FB; i++) bitmap[i] = 1'($urandom_range(0, 1));
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; line_end = 1'b0; frame = 1'b0;
    spr_x = '0; pixel_x = '0; mask = '0; bitmap = '0;
    m_line = -1;
    tick();
    tick();
    chk("reset_busy", 32'(busy), 0);
    chk("reset_draw", 32'(spr_draw), 0);
    rst = 1'b1;
    tick();

    // Single line, scaling and done
    rand_bitmap();
    bitmap[0 +: SPR_W]  = 13'b0000011110000;
    bitmap[FB +: SPR_W] = 13'b0011111111110;
    spr_x = 10'd100; mask = '1; frame = 1'b0;
    pin(109, 0); pin(110, 1); pin(117, 1); pin(118, 0);
    pin(142, 2); pin(149, 2); pin(430, 11); pin(437, 11); pin(438, 0);
    do_row(1'b1, 1, 640, 640, -1, -1, 0);
    chk("done_pulse", 32'(done), 1);
    chk("busy_at_done", 32'(busy), 0);
    tick();
    chk("done_one_cycle", 32'(done), 0);
    sweep(640, 1'b0, -1, 0);
    chk("line17_empty", 32'(nz_cnt), 0);

    // Start in the done cycle is ignored; start while busy is ignored
    spr_x = 10'd0;
    do_row(1'b1, 1, 40, 40, -1, -1, 0);
    start = 1'b1; tick();
    chk("start_in_done", 32'(busy), 0);
    start = 1'b1; tick();
    chk("start_after_done", 32'(busy), 1);
    start = 1'b1;
    do_row(1'b0, 1, 40, 40, 3, 5, 3);
    tick();
    // start with line_end in idle: the next scanline only arms
    start = 1'b1; line_end = 1'b1; tick();
    do_row(1'b0, 450, 40, 40, -1, -1, 0);
    chk("first_line_delayed", 32'(arm_nz), 0);
    tick();

    // Mask/frame latch with mid-row input changes
    spr_x = 10'd100; mask = 11'h7FE; frame = 1'b1;
    pin(104, 0); pin(123, 0); pin(135, 0); pin(136, 2); pin(155, 2); pin(156, 0); pin(360, 9);
    do_row(1'b1, 1, 640, 200, 0, 300, 1);
    chk("sprite1_never", 32'(s1_cnt), 0);
    tick();

    // Right-edge clipping
    bitmap[0 +: SPR_W] = 13'h1FFF;
    spr_x = 10'd700; mask = '1; frame = 1'b0;
    pin(699, 0); pin(700, 1); pin(725, 1); pin(726, 0); pin(1020, 11); pin(1023, 11);
    do_row(1'b1, 1, 1024, 40, -1, -1, 0);
    tick();
    spr_x = 10'd1000;
    pin(999, 0); pin(1000, 1); pin(1023, 1);
    do_row(1'b1, 1, 1024, 40, -1, -1, 0);
    tick();

    // Reset mid-row, then a full fresh row
    bitmap[0 +: SPR_W] = 13'b0000011110000;
    spr_x = 10'd100;
    do_row(1'b1, 1, 450, 450, 5, 200, 2);
    tick();
    pin(109, 0); pin(110, 1); pin(149, 2); pin(150, 0);
    do_row(1'b1, 1, 450, 450, -1, -1, 0);
    tick();

    // Randomised rows
    for (int n = 0; n < 4; n++) begin
      rand_bitmap();
      spr_x = X_W'($urandom_range(0, 1023));
      if (n == 0) spr_x = X_W'($urandom_range(0, 200));
      mask  = N_SPR'($urandom());
      frame = 1'($urandom_range(0, 1));
      do_row(1'b1, int'($urandom_range(1, 30)), -1, -1,
             int'($urandom_range(0, LINES - 1)), int'($urandom_range(0, 19)),
             ($urandom_range(0, 1) == 0) ? 1 : 3);
      tick();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sprite_row_renderer.md
Name: sprite_row_renderer

Overview:
- Parametrised successor to the fixed 11-invader row drawer.
- Renders one horizontal row of N identical scaled sprites, each individually maskable, from an externally supplied two-frame bitmap. Frame selects the animation frame.
- Sits between the game-state logic (supplies bitmap, mask, position, frame) and the VGA pixel mux. Its output names which sprite, if any, covers the current pixel.

Parameters:
- N_SPR, 11, number of sprites in the row
- SPR_W, 13, sprite bitmap width in pixels
- SPR_H, 8, sprite bitmap height in pixels
- SCALE, 2, integer scale factor (>=1) applied in both axes
- PITCH, 32, horizontal distance between left edges of adjacent sprites in screen pixels; must be >= SPR_W*SCALE
- X_W, 10, width of horizontal coordinates
- IDX_W, $clog2(N_SPR+1), width of the sprite index output

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- start  in  1  one-cycle pulse; begins a row on the next scanline
- line_end  in  1  one-cycle pulse at the end of each scanline's active region
- frame  in  1  animation frame select (0/1)
- spr_x  in  X_W  left screen x of sprite 1
- pixel_x  in  X_W  current horizontal pixel; increments by 1 per clk during active video
- mask  in  N_SPR  bit k=1 draws sprite k+1
- bitmap  in  2*SPR_H*SPR_W  both frames, flattened
- spr_draw  out  IDX_W  1..N_SPR = that sprite's opaque pixel; 0 = none
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last scaled line

Behaviour:
- Reset (rst=0 at clk edge): state IDLE; spr_draw=0, busy=0, done=0; all counters 0. Applies mid-row, with no partial output afterwards.
- States: IDLE -> ARM -> LINE -> DONE -> IDLE.
- IDLE: when start=1, latch frame, mask and spr_x, set busy=1 and go to ARM. Otherwise stay in IDLE.
- ARM: wait for line_end, then go to LINE. The row begins on the scanline after start.
- LINE: active for SPR_H*SCALE scanlines. Line counter ly runs 0..SPR_H*SCALE-1; bitmap row r = ly/SCALE.
- LINE, line_end: increment ly. If ly was the last line, go to DONE; else stay in LINE.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- Pixel rule for sprite k (0-based):
  - Base b_k = spr_x_latched + k*PITCH, computed in X_W+$clog2(N_SPR)+1 bits, with no wrap.
  - The sprite covers pixel_x in [b_k, b_k+SPR_W*SCALE-1].
  - Column c = (pixel_x-b_k)/SCALE.
  - Opaque if bitmap[f*SPR_H*SPR_W + r*SPR_W + (SPR_W-1-c)] = 1 and mask_latched[k] = 1. Column 0 is the MSB of each row word.
- Latency: spr_draw is registered. The value for pixel_x sampled at edge t appears after edge t, i.e. 1 cycle. Otherwise spr_draw=0.
- Implementation uses per-line x/scale counters started on base match, not dividers. Results must equal the rule above.
- Sprites with b_k beyond 2^X_W-1 never match and are never drawn. A partially off-screen sprite draws its visible columns only.
- line_end in the same cycle as a covered pixel: that pixel is still output. Counters reset for the next line, and remaining sprites on that line are dropped.
- start while busy: ignored. Latched values do not change mid-row.
- start and line_end in the same cycle while in IDLE: start accepted. That line_end does not count; the first drawn line is the following scanline.
- done and start in the same cycle: start ignored. Accepted from IDLE on the next cycle.
- Input changes to mask/frame/spr_x during busy have no effect until the next start.

Test Plan:
Defaults; spr_x=100; frame 0 row 0 = 0000011110000; frame 1 row 0 = 0011111111110.
- Single line: start, line_end, then sweep pixel_x 0..639 -> spr_draw=1 on cycles following pixel_x 110..117, =2 following 142..149, ... =11 following 430..437; 0 elsewhere.
- Scaling and done: run 16 line_end pulses -> rows 0,0,1,1,...,7,7 drawn. done pulses once after the 16th line_end; busy=0 the same cycle; a 17th line draws nothing.
- Mask/frame latch: mask=11'h7FE, frame=1 at start; toggle mask to all-ones mid-row -> sprite 1 never drawn. Sprite 2 is drawn following pixel_x 136..155 on line 0.
- Right-edge clip: spr_x=700 -> sprites 1..N whose bases exceed 1023 output nothing; no wrap to the low x range.
- Reset mid-row: rst=0 for one cycle during line 5 -> next cycle spr_draw=0, busy=0. A new start renders a full 16-line row from row 0.
- Collisions: start while busy is ignored; start with line_end in IDLE delays the first line by one scanline.
